counter_sweep_ctrl: RTL and testbench

Sequencer that owns and drives a WIDTH-bit up/down count register and sweeps it between a programmed start value and a limit value.
- Sweep modes: one-shot, wrap, or ping-pong.
- Programmable prescaler sets the step rate.
- Software-style interface: configure, then go/pause/stop.
- Sits between a control master and any logic consuming count and up_down (e.g. display, address sweep, PWM index).

---
 rtl/counter_sweep_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sweep_ctrl.sv
// counter_sweep_ctrl
// Owns a WIDTH-bit up/down count register and sweeps it between a programmed
// start and limit value. The sweep is one-shot, wrap or ping-pong, and a
// prescaler sets the step rate. A control master configures the block and
// then drives go/pause/stop. All outputs are registered.

module counter_sweep_ctrl #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_limit,
  input  logic [1:0]       cfg_mode,
  input  logic             cfg_dir,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic             go,
  input  logic             pause,
  input  logic             stop,
  output logic [WIDTH-1:0] count,
  output logic             up_down,
  output logic             busy,
  output logic             done,
  output logic             wrap_pulse
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_RUN,
    S_HOLD,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_WRAP = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               up_down_q, up_down_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               wrap_q, wrap_d;
  logic [DIV_W-1:0]   presc_q, presc_d;
  logic [WIDTH-1:0]   start_q, start_d;
  logic [WIDTH-1:0]   limit_q, limit_d;
  logic [1:0]         mode_q, mode_d;
  logic               dir_q, dir_d;
  logic [DIV_W-1:0]   div_q, div_d;

  logic [WIDTH-1:0]   endpoint;
  logic [WIDTH-1:0]   count_inc;
  logic [WIDTH-1:0]   count_dec;
  logic               at_end;
  logic               cfg_accept;

  // Configuration is only taken when nothing is sweeping; the endpoint flips
  // between limit and start depending on whether we still travel in the
  // configured direction.
  always_comb begin
    cfg_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
    cfg_accept = cfg_valid && cfg_ready;
    endpoint   = (up_down_q == dir_q) ? limit_q : start_q;
    at_end     = (count_q == endpoint);
    count_inc  = count_q + WIDTH'(1);
    count_dec  = count_q - WIDTH'(1);
  end

  // Next-state and step logic; stop beats pause, pause beats go/step, and a
  // new configuration in DONE beats a simultaneous go.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    up_down_d = up_down_q;
    done_d    = 1'b0;
    wrap_d    = 1'b0;
    presc_d   = presc_q;
    start_d   = start_q;
    limit_d   = limit_q;
    mode_d    = mode_q;
    dir_d     = dir_q;
    div_d     = div_q;

    if (cfg_accept) begin
      start_d   = cfg_start;
      limit_d   = cfg_limit;
      mode_d    = cfg_mode;
      dir_d     = cfg_dir;
      div_d     = cfg_div;
      count_d   = cfg_start;
      up_down_d = cfg_dir;
      state_d   = stop ? S_IDLE : S_ARMED;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (stop) begin
            state_d = S_IDLE;
          end else if (!pause && go) begin
            state_d = S_RUN;
            presc_d = '0;
          end
        end
        S_RUN: begin
          if (stop) begin
            state_d = S_IDLE;
          end else if (pause) begin
            state_d = S_HOLD;
          end else if (presc_q == div_q) begin
            presc_d = '0;
            if (!at_end) begin
              count_d = up_down_q ? count_inc : count_dec;
            end else begin
              case (mode_q)
                MODE_WRAP: begin
                  count_d = start_q;
                  wrap_d  = 1'b1;
                end
                MODE_PING: begin
                  up_down_d = ~up_down_q;
                  wrap_d    = 1'b1;
                  if (start_q != limit_q) begin
                    count_d = up_down_q ? count_dec : count_inc;
                  end
                end
                default: begin
                  state_d = S_DONE;
                  done_d  = 1'b1;
                end
              endcase
            end
          end else begin
            presc_d = presc_q + DIV_W'(1);
          end
        end
        S_HOLD: begin
          if (stop) begin
            state_d = S_IDLE;
          end else if (!pause) begin
            state_d = S_RUN;
          end
        end
        S_DONE: begin
          if (stop) begin
            state_d = S_IDLE;
          end else if (!pause && go) begin
            count_d   = start_q;
            up_down_d = dir_q;
            presc_d   = '0;
            state_d   = S_RUN;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    busy_d = (state_d == S_RUN) || (state_d == S_HOLD);
  end

  // State, count and configuration registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= '0;
      up_down_q <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
      presc_q   <= '0;
      start_q   <= '0;
      limit_q   <= '0;
      mode_q    <= '0;
      dir_q     <= 1'b0;
      div_q     <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      up_down_q <= up_down_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      wrap_q    <= wrap_d;
      presc_q   <= presc_d;
      start_q   <= start_d;
      limit_q   <= limit_d;
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      div_q     <= div_d;
    end
  end

  assign count      = count_q;
  assign up_down    = up_down_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_counter_sweep_ctrl.sv
// tb_counter_sweep_ctrl
// Directed stimulus pushes the hand-computed output state expected after each
// clock edge into a queue; an independent monitor pops and compares on the
// falling edge.

module tb_counter_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [3:0] cfg_start = '0;
  logic [3:0] cfg_limit = '0;
  logic [1:0] cfg_mode = '0;
  logic       cfg_dir = 1'b0;
  logic [7:0] cfg_div = '0;
  logic       go = 1'b0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;
  logic [3:0] count;
  logic       up_down;
  logic       busy;
  logic       done;
  logic       wrap_pulse;

  counter_sweep_ctrl #(.WIDTH(4), .DIV_W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_start  (cfg_start),
    .cfg_limit  (cfg_limit),
    .cfg_mode   (cfg_mode),
    .cfg_dir    (cfg_dir),
    .cfg_div    (cfg_div),
    .go         (go),
    .pause      (pause),
    .stop       (stop),
    .count      (count),
    .up_down    (up_down),
    .busy       (busy),
    .done       (done),
    .wrap_pulse (wrap_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         tag;
    logic [8:0] vec;
    string      name;
  } exp_t;

  exp_t expQ[$];
  int   cyc = 0;
  int   compared = 0;
  int   mismatched = 0;

  // Cycle index used to line expectations up with the edge they describe.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input exp_t e);
    logic [8:0] act;
    act = {count, up_down, busy, done, wrap_pulse, cfg_ready};
    compared++;
    if (act !== e.vec) begin
      mismatched++;
      $display("[TB] FAIL %s cycle %0d: got count=%0d ud/busy/done/wrap/ready=%b, expected count=%0d ud/busy/done/wrap/ready=%b",
               e.name, cyc, act[8:5], act[4:0], e.vec[8:5], e.vec[4:0]);
    end
  endtask

  // Monitor: compare every expectation whose edge has just happened.
  always @(negedge clk) begin
    while (expQ.size() > 0 && expQ[0].tag <= cyc) begin
      exp_t e;
      e = expQ.pop_front();
      if (e.tag < cyc) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL %s stale: got no check at cycle %0d, expected check at cycle %0d", e.name, cyc, e.tag);
      end else begin
        checkOutput(e);
      end
    end
  end

  // eFlags layout: {up_down, busy, done, wrap_pulse, cfg_ready}
  task automatic applyStimulus(input string name, input logic [3:0] eCount, input logic [4:0] eFlags);
    exp_t e;
    e.tag  = cyc + 1;
    e.vec  = {eCount, eFlags};
    e.name = name;
    expQ.push_back(e);
    @(negedge clk);
    #1;
    go        = 1'b0;
    stop      = 1'b0;
    cfg_valid = 1'b0;
    rst       = 1'b0;
  endtask

  task automatic setCfg(input logic [3:0] s, input logic [3:0] l, input logic [1:0] m,
                        input logic d, input logic [7:0] dv);
    cfg_start = s;
    cfg_limit = l;
    cfg_mode  = m;
    cfg_dir   = d;
    cfg_div   = dv;
    cfg_valid = 1'b1;
  endtask

  initial begin
    @(negedge clk);
    #1;
    rst = 1'b1;
    applyStimulus("reset", 4'd0, 5'b10001);

    // One-shot up 3..6, then go from DONE restarts at start.
    setCfg(4'd3, 4'd6, 2'b00, 1'b1, 8'd0);
    applyStimulus("os_cfg", 4'd3, 5'b10000);
    go = 1'b1;
    applyStimulus("os_go", 4'd3, 5'b11000);
    applyStimulus("os_step4", 4'd4, 5'b11000);
    applyStimulus("os_step5", 4'd5, 5'b11000);
    applyStimulus("os_step6", 4'd6, 5'b11000);
    applyStimulus("os_done", 4'd6, 5'b10101);
    applyStimulus("os_done_one", 4'd6, 5'b10001);
    go = 1'b1;
    applyStimulus("done_go", 4'd3, 5'b11000);
    applyStimulus("rerun4", 4'd4, 5'b11000);
    applyStimulus("rerun5", 4'd5, 5'b11000);
    applyStimulus("rerun6", 4'd6, 5'b11000);
    applyStimulus("os_done2", 4'd6, 5'b10101);

    // Wrap 14..1 across the modulo boundary; config in DONE beats go.
    setCfg(4'd14, 4'd1, 2'b01, 1'b1, 8'd0);
    go = 1'b1;
    applyStimulus("cfg_beats_go", 4'd14, 5'b10000);
    go = 1'b1;
    applyStimulus("wr_go", 4'd14, 5'b11000);
    applyStimulus("wr_15", 4'd15, 5'b11000);
    applyStimulus("wr_0", 4'd0, 5'b11000);
    applyStimulus("wr_1", 4'd1, 5'b11000);
    applyStimulus("wr_wrap", 4'd14, 5'b11010);
    applyStimulus("wr_15b", 4'd15, 5'b11000);
    applyStimulus("wr_0b", 4'd0, 5'b11000);
    setCfg(4'd5, 4'd9, 2'b10, 1'b0, 8'd3);
    applyStimulus("cfg_in_run", 4'd1, 5'b11000);
    applyStimulus("cfg_ignored", 4'd14, 5'b11010);
    stop = 1'b1;
    applyStimulus("stop_run", 4'd14, 5'b10001);

    // Ping-pong up 2..4.
    setCfg(4'd2, 4'd4, 2'b10, 1'b1, 8'd0);
    applyStimulus("pp_cfg", 4'd2, 5'b10000);
    go = 1'b1;
    applyStimulus("pp_go", 4'd2, 5'b11000);
    applyStimulus("pp_3", 4'd3, 5'b11000);
    applyStimulus("pp_4", 4'd4, 5'b11000);
    applyStimulus("pp_bounce_dn", 4'd3, 5'b01010);
    applyStimulus("pp_2", 4'd2, 5'b01000);
    applyStimulus("pp_bounce_up", 4'd3, 5'b11010);
    applyStimulus("pp_4b", 4'd4, 5'b11000);
    stop = 1'b1;
    applyStimulus("pp_stop", 4'd4, 5'b10001);

    // Ping-pong down 9..7.
    setCfg(4'd9, 4'd7, 2'b10, 1'b0, 8'd0);
    applyStimulus("ppd_cfg", 4'd9, 5'b00000);
    go = 1'b1;
    applyStimulus("ppd_go", 4'd9, 5'b01000);
    applyStimulus("ppd_8", 4'd8, 5'b01000);
    applyStimulus("ppd_7", 4'd7, 5'b01000);
    applyStimulus("ppd_bounce_up", 4'd8, 5'b11010);
    applyStimulus("ppd_9", 4'd9, 5'b11000);
    applyStimulus("ppd_bounce_dn", 4'd8, 5'b01010);
    applyStimulus("ppd_7b", 4'd7, 5'b01000);
    stop = 1'b1;
    applyStimulus("ppd_stop", 4'd7, 5'b00001);

    // Ping-pong with start == limit holds count and pulses every step.
    setCfg(4'd5, 4'd5, 2'b10, 1'b1, 8'd0);
    applyStimulus("ppe_cfg", 4'd5, 5'b10000);
    go = 1'b1;
    applyStimulus("ppe_go", 4'd5, 5'b11000);
    applyStimulus("ppe_flip1", 4'd5, 5'b01010);
    applyStimulus("ppe_flip2", 4'd5, 5'b11010);
    stop = 1'b1;
    applyStimulus("ppe_stop", 4'd5, 5'b10001);

    // Prescaler div=2 with a 5-cycle pause mid-interval, then stop in HOLD.
    setCfg(4'd0, 4'd15, 2'b01, 1'b1, 8'd2);
    applyStimulus("ps_cfg", 4'd0, 5'b10000);
    go = 1'b1;
    applyStimulus("ps_go", 4'd0, 5'b11000);
    applyStimulus("ps_wait1", 4'd0, 5'b11000);
    applyStimulus("ps_wait2", 4'd0, 5'b11000);
    applyStimulus("ps_step", 4'd1, 5'b11000);
    applyStimulus("ps_mid", 4'd1, 5'b11000);
    pause = 1'b1;
    for (int i = 0; i < 5; i++) applyStimulus("ps_paused", 4'd1, 5'b11000);
    pause = 1'b0;
    applyStimulus("ps_release", 4'd1, 5'b11000);
    applyStimulus("ps_remain", 4'd1, 5'b11000);
    applyStimulus("ps_resume_step", 4'd2, 5'b11000);
    pause = 1'b1;
    applyStimulus("ps_hold", 4'd2, 5'b11000);
    stop = 1'b1;
    applyStimulus("stop_hold", 4'd2, 5'b10001);
    pause = 1'b0;

    // go and stop together in ARMED; go alone in IDLE does nothing.
    setCfg(4'd7, 4'd9, 2'b00, 1'b1, 8'd0);
    applyStimulus("gs_cfg", 4'd7, 5'b10000);
    go   = 1'b1;
    stop = 1'b1;
    applyStimulus("go_stop_armed", 4'd7, 5'b10001);
    go = 1'b1;
    applyStimulus("go_idle", 4'd7, 5'b10001);

    // Reset in the middle of a downward sweep.
    setCfg(4'd7, 4'd0, 2'b00, 1'b0, 8'd0);
    applyStimulus("rs_cfg", 4'd7, 5'b00000);
    go = 1'b1;
    applyStimulus("rs_go", 4'd7, 5'b01000);
    applyStimulus("rs_6", 4'd6, 5'b01000);
    applyStimulus("rs_5", 4'd5, 5'b01000);
    rst = 1'b1;
    applyStimulus("reset_mid", 4'd0, 5'b10001);

    @(negedge clk);
    @(negedge clk);
    while (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      compared++;
      mismatched++;
      $display("[TB] FAIL %s unchecked: got no check, expected check at cycle %0d", e.name, e.tag);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
